// File: rtl/serial_add8_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned W_DEF = 8;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_add8_if.sv
// Start/busy/done handshake plus operand and result buses for serial_add8.
interface serial_add8_if
    import serial_add_pkg::*;
#(
    parameter int unsigned W = W_DEF
) ();

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, s, cout, ovf
    );

endinterface

// File: rtl/serial_add8_full_adder1.sv
// One-bit full adder used as the serial bit slice.
module full_adder1 (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = x ^ y ^ ci;
    assign co  = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add8.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock.
module serial_add8
    import serial_add_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    serial_add8_if.slave   bus
);

    localparam int unsigned CW = clog2(W);

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          sbit;
    logic          nc;

    full_adder1 u_fa (
        .x   (a_sh[0]),
        .y   (b_sh[0]),
        .ci  (carry),
        .sum (sbit),
        .co  (nc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.s    <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry.
                        a_sh     <= bus.a;
                        b_sh     <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub;
                        cnt      <= '0;
                        bus.cout <= 1'b0;
                        bus.ovf  <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bus.s <= {sbit, bus.s[W-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= nc;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        bus.ovf  <= carry ^ nc;
                        bus.cout <= nc;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add8.sv
// Randomized and directed checks of serial_add8 against an arithmetic model.
module tb_serial_add8;
    import serial_add_pkg::*;

    localparam int unsigned W = 8;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    serial_add8_if #(.W(W)) bus ();

    serial_add8 #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed difference/sum in wide integers, wrapped to W bits.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, output logic [W-1:0] es,
                                  output logic ec, output logic eo);
        longint ua, ub, sa, sb, res;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = sub ? (sa - sb) : (sa + sb);
        es  = W'(res);
        ec  = sub ? (ua >= ub) : ((ua + ub) >= (longint'(1) << W));
        eo  = (res < -(longint'(1) << (W - 1))) || (res > ((longint'(1) << (W - 1)) - 1));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation and reports observations; callers do the comparing.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output logic [W-1:0] rs, output logic rc, output logic ro,
                          output int lat, output int bcnt, output logic hold_ok,
                          output logic accept_ok, output logic timeout);
        bus.a = a;
        bus.b = b;
        bus.sub = sub;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        accept_ok = (bus.busy === 1'b1) && (bus.cout === 1'b0) && (bus.ovf === 1'b0) && (bus.done === 1'b0);
        bcnt = bus.busy ? 1 : 0;
        lat = 0;
        timeout = 1'b1;
        for (int i = 0; i < 4 * W; i++) begin
            step();
            lat++;
            if (bus.done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (bus.busy === 1'b1) bcnt++;
        end
        rs = bus.s;
        rc = bus.cout;
        ro = bus.ovf;
        step();
        hold_ok = (bus.done === 1'b0) && (bus.busy === 1'b0) && (bus.s === rs)
                  && (bus.cout === rc) && (bus.ovf === ro);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) step();
        reset = 1'b0;
        step();
        vectors++;
        if ({bus.busy, bus.done, bus.s, bus.cout, bus.ovf} !== '0) begin
            miscompares++;
            $display("FAIL reset_state busy=%b done=%b s=%h cout=%b ovf=%b required all zero",
                     bus.busy, bus.done, bus.s, bus.cout, bus.ovf);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[7];
        logic [W-1:0] tb[7];
        logic         tsub[7];
        logic [W-1:0] xs[7];
        logic         xc[7];
        logic         xo[7];
        logic [W-1:0] rs;
        logic rc, ro, hold_ok, acc_ok, tmo;
        int lat, bcnt;
        ta   = '{8'h9C, 8'h7F, 8'h80, 8'h35, 8'h35, 8'h80, 8'h00};
        tb   = '{8'h35, 8'h01, 8'h01, 8'h64, 8'h64, 8'h80, 8'h80};
        tsub = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
        xs   = '{8'hD1, 8'h80, 8'h7F, 8'hD1, 8'h99, 8'h00, 8'h80};
        xc   = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
        xo   = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], tsub[i], rs, rc, ro, lat, bcnt, hold_ok, acc_ok, tmo);
            vectors++;
            if (tmo !== 1'b0 || {rs, rc, ro} !== {xs[i], xc[i], xo[i]}) begin
                miscompares++;
                $display("FAIL directed[%0d] s=%h cout=%b ovf=%b timeout=%b required s=%h cout=%b ovf=%b",
                         i, rs, rc, ro, tmo, xs[i], xc[i], xo[i]);
            end
            vectors++;
            if (lat !== W || bcnt !== W) begin
                miscompares++;
                $display("FAIL directed_timing[%0d] done_after=%0d busy_cycles=%0d required %0d and %0d",
                         i, lat, bcnt, W, W);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, rs, es;
        logic sub, rc, ro, ec, eo, hold_ok, acc_ok, tmo;
        logic [W-1:0] corner[4];
        int lat, bcnt;
        corner = '{8'h00, 8'h80, 8'h7F, 8'hFF};
        for (int n = 0; n < 40; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) b = corner[$urandom_range(0, 3)];
            sub = 1'($urandom_range(0, 1));
            model(a, b, sub, es, ec, eo);
            run_op(a, b, sub, rs, rc, ro, lat, bcnt, hold_ok, acc_ok, tmo);
            vectors++;
            if (tmo !== 1'b0 || {rs, rc, ro} !== {es, ec, eo}) begin
                miscompares++;
                $display("FAIL random a=%h b=%h sub=%b got s=%h cout=%b ovf=%b timeout=%b required s=%h cout=%b ovf=%b",
                         a, b, sub, rs, rc, ro, tmo, es, ec, eo);
            end
            vectors++;
            if (lat !== W || bcnt !== W || hold_ok !== 1'b1 || acc_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL random_handshake done_after=%0d busy_cycles=%0d hold=%b accept=%b required %0d %0d 1 1",
                         lat, bcnt, hold_ok, acc_ok, W, W);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic seen;
        bus.a = 8'h9C;
        bus.b = 8'h35;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (2) step();
        bus.a = 8'h01;
        bus.b = 8'h01;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 * W; i++) begin
            step();
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (seen !== 1'b1 || bus.s !== 8'hD1) begin
            miscompares++;
            $display("FAIL busy_start_ignored s=%h done_seen=%b required s=d1 done_seen=1", bus.s, seen);
        end
        // start raised during the DONE cycle and held one more cycle
        bus.start = 1'b1;
        step();
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_start_ignored busy=%b required 0", bus.busy);
        end
        step();
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_after_done busy=%b required 1", bus.busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 4 * W; i++) begin
            step();
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (seen !== 1'b1 || bus.s !== 8'h02 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back s=%h cout=%b ovf=%b done_seen=%b required s=02 cout=0 ovf=0 done_seen=1",
                     bus.s, bus.cout, bus.ovf, seen);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] rs;
        logic rc, ro, hold_ok, acc_ok, tmo, seen;
        int lat, bcnt;
        bus.a = 8'h9C;
        bus.b = 8'h35;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({bus.busy, bus.done, bus.s, bus.cout, bus.ovf} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid busy=%b done=%b s=%h cout=%b ovf=%b required all zero",
                     bus.busy, bus.done, bus.s, bus.cout, bus.ovf);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done activity=%b required 0", seen);
        end
        run_op(8'hFF, 8'hFF, 1'b0, rs, rc, ro, lat, bcnt, hold_ok, acc_ok, tmo);
        vectors++;
        if (tmo !== 1'b0 || {rs, rc, ro} !== {8'hFE, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL after_reset_op s=%h cout=%b ovf=%b timeout=%b required s=fe cout=1 ovf=0",
                     rs, rc, ro, tmo);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
